// File: rtl/tan_fp32_seq.sv
// Sequential fp32 tangent: special cases are classified at accept, the usual
// path reduces to [0, pi/4] (cotangent swap above that), evaluates sin and cos
// Taylor polynomials by Horner on one shared MUL, ADD and DIVIDE, then
// divides. The sign of x is restored on the result because tan is odd.
// Optional feature macro TAN_ERR_FLAG_EN adds the err output.
// Ports:
//   clk, rst (async, active-high)
//   in_valid/in_ready/x_in     : operand handshake, fp32 radians
//   out_valid/out_ready/tan_out: result handshake, fp32
//   err (TAN_ERR_FLAG_EN only)   : result came from NaN, inf or |x| >= pi/2
module tan_fp32_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] x_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] tan_out
`ifdef TAN_ERR_FLAG_EN
    ,
    output logic        err
`endif
);
    localparam logic [31:0] HALF_PI    = 32'h3FC90FDB;
    localparam logic [31:0] QUARTER_PI = 32'h3F490FDB;
    localparam logic [7:0]  TINY_EXP   = 8'd103;
    localparam logic [31:0] QNAN       = 32'h7FC00000;
    localparam logic [31:0] ONE        = 32'h3F800000;
    localparam logic [31:0] C9         = 32'h3638EF1D;   // 1/362880
    localparam logic [31:0] K8         = 32'h37D00D01;   // 1/40320

    typedef enum logic [2:0] {IDLE, RED, SQ, SIN, SINR, COS, DIV, RESULT} state_t;

    state_t      state;
    logic [2:0]  step;
    logic [31:0] a_reg, r, r2, acc, s;
    logic        swap, sgn;

    // Additive Horner coefficients, indexed by ADD step: c7, c5, c3, 1.
    function automatic logic [31:0] sin_coef(input logic [1:0] i);
        case (i)
            2'd0:    sin_coef = 32'hB9500D01;
            2'd1:    sin_coef = 32'h3C088889;
            2'd2:    sin_coef = 32'hBE2AAAAB;
            default: sin_coef = ONE;
        endcase
    endfunction

    // Additive Horner coefficients, indexed by ADD step: k6, k4, k2, 1.
    function automatic logic [31:0] cos_coef(input logic [1:0] i);
        case (i)
            2'd0:    cos_coef = 32'hBAB60B61;
            2'd1:    cos_coef = 32'h3D2AAAAB;
            2'd2:    cos_coef = 32'hBF000000;
            default: cos_coef = ONE;
        endcase
    endfunction

    // Normal-operand multiply, round to nearest even; zero if either is zero.
    function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
        logic [47:0] p;
        logic [7:0]  e;
        logic [22:0] m;
        logic        rnd, sticky;
        p      = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
        e      = a[30:23] + b[30:23] - 8'd127 + 8'(p[47]);
        m      = p[47] ? p[46:24] : p[45:23];
        rnd    = p[47] ? p[23] : p[22];
        sticky = p[47] ? |p[22:0] : |p[21:0];
        fp_mul = {a[31] ^ b[31], e, m} + 32'(rnd & (sticky | m[0]));
        if (a[30:23] == 8'd0 || b[30:23] == 8'd0) fp_mul = '0;
    endfunction

    // Signed add of normal operands with 3 guard bits, round to nearest even.
    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] x, y;
        logic [7:0]  d, e;
        logic [27:0] mx, my, sum, nrm;
        logic        found, rnd, sticky;
        int          lz;
        if (a[30:0] >= b[30:0]) begin x = a; y = b; end
        else begin x = b; y = a; end
        d   = x[30:23] - y[30:23];
        mx  = {2'b01, x[22:0], 3'b000};
        my  = (y[30:23] == 8'd0) ? 28'd0 : ({2'b01, y[22:0], 3'b000} >> d);
        sum = (x[31] == y[31]) ? mx + my : mx - my;
        lz = 0;
        found = 1'b0;
        for (int i = 27; i >= 0; i--) begin
            if (!found && sum[i]) begin
                found = 1'b1;
                lz    = 27 - i;
            end
        end
        nrm    = sum << lz;
        e      = x[30:23] + 8'd1 - 8'(lz);
        rnd    = nrm[3];
        sticky = |nrm[2:0];
        fp_add = {x[31], e, nrm[26:4]} + 32'(rnd & (sticky | nrm[4]));
        if (!nrm[27] || x[30:23] == 8'd0) fp_add = '0;
    endfunction

    // Normal-operand divide, quotient kept to one extra bit and rounded half-up.
    function automatic logic [31:0] fp_div(input logic [31:0] a, input logic [31:0] b);
        logic [48:0] num, den;
        logic [25:0] q;
        logic [7:0]  e;
        logic [22:0] m;
        num    = {1'b1, a[22:0], 25'd0};
        den    = 49'({1'b1, b[22:0]});
        q      = 26'(num / den);
        e      = a[30:23] - b[30:23] + 8'd126 + 8'(q[25]);
        m      = q[25] ? q[24:2] : q[23:1];
        fp_div = {a[31] ^ b[31], e, m} + 32'(q[25] ? q[1] : q[0]);
    endfunction

    // Accept-time classification on the magnitude.
    logic [31:0] a_abs, spec_val;
    logic        is_nan, out_dom, spec_hit;
    assign a_abs    = {1'b0, x_in[30:0]};
    assign is_nan   = (x_in[30:23] == 8'hFF) && (x_in[22:0] != 23'd0);
    assign out_dom  = a_abs >= HALF_PI;   // covers inf as well
    assign spec_hit = is_nan || out_dom || (x_in[30:23] < TINY_EXP);
    assign spec_val = (!is_nan && out_dom) ? QNAN : x_in;
`ifdef TAN_ERR_FLAG_EN
    logic spec_err;
    assign spec_err = is_nan || out_dom;
`endif

    // Operand steering for the shared operators.
    logic [31:0] mul_a, mul_b, add_a, add_b, div_a, div_b;
    logic [31:0] mul_res, add_res, div_res;
    always_comb begin
        mul_a = acc;
        mul_b = r2;
        add_a = acc;
        add_b = ONE;
        div_a = s;
        div_b = acc;
        case (state)
            RED:  begin add_a = HALF_PI; add_b = {1'b1, a_reg[30:0]}; end
            SQ:   begin mul_a = r; mul_b = r; end
            SIN:  begin
                      if (step == 3'd0) mul_a = C9;
                      add_b = sin_coef(step[2:1]);
                  end
            SINR: begin mul_a = r; mul_b = acc; end
            COS:  begin
                      if (step == 3'd0) mul_a = K8;
                      add_b = cos_coef(step[2:1]);
                  end
            DIV:  if (swap) begin div_a = acc; div_b = s; end
            default: ;
        endcase
    end

    assign mul_res = fp_mul(mul_a, mul_b);
    assign add_res = fp_add(add_a, add_b);
    assign div_res = fp_div(div_a, div_b);

    // Control FSM and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            tan_out   <= '0;
            step      <= '0;
            a_reg     <= '0;
            r         <= '0;
            r2        <= '0;
            acc       <= '0;
            s         <= '0;
            swap      <= 1'b0;
            sgn       <= 1'b0;
`ifdef TAN_ERR_FLAG_EN
            err       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (in_valid && in_ready) begin
                    in_ready <= 1'b0;
                    sgn      <= x_in[31];
                    a_reg    <= a_abs;
                    step     <= '0;
                    if (spec_hit) begin
                        tan_out   <= spec_val;
                        out_valid <= 1'b1;
`ifdef TAN_ERR_FLAG_EN
                        err       <= spec_err;
`endif
                        state     <= RESULT;
                    end else begin
                        state <= RED;
                    end
                end
                RED: begin
                    if (a_reg <= QUARTER_PI) begin
                        r    <= a_reg;
                        swap <= 1'b0;
                    end else begin
                        r    <= add_res;
                        swap <= 1'b1;
                    end
                    state <= SQ;
                end
                SQ: begin
                    r2    <= mul_res;
                    state <= SIN;
                end
                SIN: begin
                    acc  <= step[0] ? add_res : mul_res;
                    step <= step + 3'd1;
                    if (step == 3'd7) state <= SINR;
                end
                SINR: begin
                    s     <= mul_res;
                    state <= COS;
                end
                COS: begin
                    acc  <= step[0] ? add_res : mul_res;
                    step <= step + 3'd1;
                    if (step == 3'd7) state <= DIV;
                end
                DIV: begin
                    // quotient of two positives: its sign bit is 0, x's sign wins
                    tan_out   <= {sgn ^ div_res[31], div_res[30:0]};
                    out_valid <= 1'b1;
`ifdef TAN_ERR_FLAG_EN
                    err       <= 1'b0;
`endif
                    state     <= RESULT;
                end
                RESULT: if (out_ready) begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tan_fp32_seq.sv
// Scoreboard bench for tan_fp32_seq: the driver pushes each accepted operand,
// the monitor pops on out_valid and judges value, latency and handshake
// against a real-arithmetic tangent reference.
module tb_tan_fp32_seq;
    localparam logic [31:0] QNAN = 32'h7FC00000;
    localparam logic [31:0] ONE  = 32'h3F800000;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] x_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] tan_out;
`ifdef TAN_ERR_FLAG_EN
    logic        err;
`endif

    int unsigned cyc = 0;
    int          checks = 0;
    int          passed = 0;

    typedef struct {
        logic [31:0] x;
        int unsigned acc_cyc;
        int unsigned hold;
    } txn_t;
    txn_t sb[$];

    tan_fp32_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_in      (x_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .tan_out   (tan_out)
`ifdef TAN_ERR_FLAG_EN
        ,
        .err       (err)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input bit ok, input string got, input string want);
        checks++;
        if (ok) passed++;
        else $display("FAIL %s: got %s, expected %s (t=%0t)", name, got, want, $time);
    endtask

    function automatic real fabs(input real v);
        return (v < 0.0) ? -v : v;
    endfunction

    function automatic real b2r(input logic [31:0] b);
        real m;
        int  e;
        e = int'(b[30:23]);
        if (e == 0) m = real'(b[22:0]) * (2.0 ** -149);
        else        m = (1.0 + real'(b[22:0]) / 8388608.0) * (2.0 ** (e - 127));
        return b[31] ? -m : m;
    endfunction

    // Reference: exact bits for special inputs, else the real tangent.
    function automatic void ref_model(input logic [31:0] x, output bit special,
                                      output logic [31:0] val, output bit e, output real t);
        real mag;
        mag = fabs(b2r(x));
        special = 1'b1;
        e = 1'b0;
        val = x;
        t = 0.0;
        if (x[30:23] == 8'hFF) begin
            e = 1'b1;
            val = (x[22:0] != 23'd0) ? x : QNAN;
        end else if (mag >= b2r(32'h3FC90FDB)) begin
            e = 1'b1;
            val = QNAN;
        end else if (mag >= 2.0 ** -24) begin
            special = 1'b0;
            t = $tan(b2r(x));
        end
    endfunction

    task automatic send(input logic [31:0] x, input int unsigned hold);
        int unsigned waited;
        txn_t t;
        waited = 0;
        @(negedge clk);
        in_valid = 1'b1;
        x_in = x;
        while (!in_ready && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            check("accept_timeout", 1'b0, "no in_ready", "in_ready within 300 cycles");
            in_valid = 1'b0;
            return;
        end
        t.x = x;
        t.acc_cyc = cyc + 1;
        t.hold = hold;
        sb.push_back(t);
        @(negedge clk);
        in_valid = 1'b0;
        x_in = $urandom;
        check("in_ready_after_accept", in_ready == 1'b0, $sformatf("%b", in_ready), "0");
    endtask

    function automatic logic [31:0] rand_x();
        logic [31:0] x;
        logic [22:0] m;
        logic [7:0]  e;
        m = 23'($urandom);
        case ($urandom_range(0, 9))
            0: case ($urandom_range(0, 3))
                   0: x = 32'h7F800000;
                   1: x = {1'b0, 8'hFF, m | 23'd1};
                   2: x = 32'h3FC90FDB + $urandom_range(0, 1000);
                   default: x = {1'b0, 8'($urandom_range(128, 254)), m};
               endcase
            1: x = {1'b0, 8'($urandom_range(0, 102)), m};
            2: x = {1'b0, 8'($urandom_range(103, 112)), m};
            3: x = {1'b0, 8'd127, 23'($urandom_range(32'h400001, 32'h490FDA))};
            default: begin
                e = 8'($urandom_range(113, 127));
                x = {1'b0, e, (e == 8'd127 && m > 23'h400000) ? (m & 23'h3FFFFF) : m};
            end
        endcase
        x[31] = 1'($urandom_range(0, 1));
        return x;
    endfunction

    // Monitor: judge each new result, then watch it stay put until released.
    initial begin : monitor
        bit          seen;
        bit          special, want_err, ok;
        int unsigned held, lat, want_lat;
        logic [31:0] last, want_val;
        real         want_t, got_t;
        txn_t        t;
        seen = 1'b0;
        held = 0;
        last = '0;
        out_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                seen = 1'b0;
                out_ready = 1'b0;
                continue;
            end
            if (out_ready) begin
                check("release_idle", !out_valid && in_ready,
                      $sformatf("out_valid=%b in_ready=%b", out_valid, in_ready), "out_valid=0 in_ready=1");
                out_ready = 1'b0;
                seen = 1'b0;
            end
            if (out_valid) begin
                if (!seen) begin
                    if (sb.size() == 0) begin
                        check("unexpected_output", 1'b0, $sformatf("%h", tan_out), "no output");
                        t.hold = 0;
                    end else begin
                        t = sb.pop_front();
                        ref_model(t.x, special, want_val, want_err, want_t);
                        if (special) begin
                            check($sformatf("special_val x=%h", t.x), tan_out == want_val,
                                  $sformatf("%h", tan_out), $sformatf("%h", want_val));
                        end else begin
                            got_t = b2r(tan_out);
                            ok = (tan_out[31] == t.x[31]);
                            if (fabs(b2r(t.x)) <= 1.5)
                                ok = ok && (fabs(got_t - want_t) <= fabs(want_t) * (2.0 ** -18));
                            else
                                ok = ok && (fabs(got_t) >= 14.0) && (tan_out[30:23] != 8'hFF);
                            check($sformatf("tan_val x=%h", t.x), ok,
                                  $sformatf("%h (%g)", tan_out, got_t), $sformatf("%g", want_t));
                        end
                        lat = cyc - t.acc_cyc + 1;
                        want_lat = special ? 1 : 21;
                        check($sformatf("latency x=%h", t.x), lat == want_lat,
                              $sformatf("%0d", lat), $sformatf("%0d", want_lat));
                        check("in_ready_busy", in_ready == 1'b0, $sformatf("%b", in_ready), "0");
`ifdef TAN_ERR_FLAG_EN
                        check($sformatf("err x=%h", t.x), err == want_err,
                              $sformatf("%b", err), $sformatf("%b", want_err));
`endif
                    end
                    seen = 1'b1;
                    held = 0;
                    last = tan_out;
                end else begin
                    held++;
                    check("hold_stable", tan_out == last, $sformatf("%h", tan_out), $sformatf("%h", last));
                    check("hold_in_ready", in_ready == 1'b0, $sformatf("%b", in_ready), "0");
                end
                if (held >= t.hold) out_ready = 1'b1;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int unsigned n;
        rst = 1'b1;
        in_valid = 1'b0;
        x_in = '0;
        #12;
        check("reset_in_ready", in_ready == 1'b1, $sformatf("%b", in_ready), "1");
        check("reset_out_valid", out_valid == 1'b0, $sformatf("%b", out_valid), "0");
        check("reset_tan_out", tan_out == 32'd0, $sformatf("%h", tan_out), "00000000");
`ifdef TAN_ERR_FLAG_EN
        check("reset_err", err == 1'b0, $sformatf("%b", err), "0");
`endif
        @(negedge clk);
        rst = 1'b0;

        // Usual path, both reductions.
        send(ONE, 0);
        send(32'hBF000000, 0);
        send(32'h3FC00000, 0);

        // Special and pass-through cases.
        send(32'h00000000, 0);
        send(32'h80000000, 0);
        send(32'h7F800000, 0);
        send(32'h3FC90FDB, 0);
        send(32'h7FC12345, 0);
        send(32'h3089705F, 0);

        // Backpressure, then an operand waiting for the return to IDLE.
        send(32'h3E99999A, 5);
        send(32'hBF333333, 0);

        // Reset ten cycles into an operation aborts it.
        send(ONE, 0);
        repeat (9) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_out_valid", out_valid == 1'b0, $sformatf("%b", out_valid), "0");
        check("abort_in_ready", in_ready == 1'b1, $sformatf("%b", in_ready), "1");
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        send(ONE, 0);

        for (int i = 0; i < 60; i++) send(rand_x(), $urandom_range(0, 2));

        n = 0;
        while ((sb.size() != 0 || out_valid) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("drain", sb.size() == 0 && !out_valid,
              $sformatf("pending=%0d out_valid=%b", sb.size(), out_valid), "pending=0 out_valid=0");
        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
